// File: rtl/tb_sim_ctrl.sv
// Simulation-control peripheral: merges per-hart stdout channels into one line-atomic stream and latches the first terminal event.
// Optional TB_SIM_CTRL_LINE_TAG_EN prefixes every granted line with "<ch>:" tag beats.

module tb_sim_ctrl_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       nl_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt, r_nl;
  logic          w_push_nl, w_pop_nl;

  assign head_o    = r_mem[r_rp];
  assign full_o    = (r_cnt == FULL);
  assign empty_o   = (r_cnt == '0);
  assign nl_o      = (r_nl != '0);
  assign w_push_nl = push_i && (wdata_i == 8'h0A);
  assign w_pop_nl  = pop_i && (head_o == 8'h0A);

  always_ff @(posedge clk_i) if (push_i) r_mem[r_wp] <= wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_nl <= '0;
    end else if (flush_i) begin
      r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_nl <= '0;
    end else begin
      if (push_i) r_wp <= r_wp + AW'(1);
      if (pop_i)  r_rp <= r_rp + AW'(1);
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + ONE;
        2'b01:   r_cnt <= r_cnt - ONE;
        default: ;
      endcase
      case ({w_push_nl, w_pop_nl})
        2'b10:   r_nl <= r_nl + ONE;
        2'b01:   r_nl <= r_nl - ONE;
        default: ;
      endcase
    end
  end
endmodule

module tb_sim_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 32,
  parameter int DRAIN_MAX  = 1024,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_CH-1:0]     print_valid_i,
  input  logic [8*NUM_CH-1:0]   print_wdata_i,
  output logic [NUM_CH-1:0]     print_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CHW-1:0]        out_ch_o,
  output logic [7:0]            out_char_o,
  input  logic                  tests_passed_i,
  input  logic                  tests_failed_i,
  input  logic                  exit_valid_i,
  input  logic [31:0]           exit_value_i,
  input  logic [CNT_W-1:0]      max_cycles_i,
  output logic                  done_o,
  output logic [2:0]            status_o,
  output logic [31:0]           exit_code_o,
  output logic [CNT_W-1:0]      cycle_cnt_o
);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [CHW-1:0] LAST_CH    = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [NUM_CH-1:0]      w_full, w_empty, w_nl, w_elig, w_push, w_pop;
  logic [NUM_CH-1:0][7:0] w_head;
  logic                   r_up, r_lock;
  logic [CHW-1:0]         r_gnt, r_ptr, w_gnt_idx;
  logic                   w_gnt_found, w_tag_vld, w_data_vld, w_pop_any, w_unlock;
  logic                   w_flush, w_drain_to, w_run, w_to, w_evt, w_empty_sel;
  logic [7:0]             w_tag_char, w_head_sel;
  logic [2:0]             r_status, w_evt_status;
  logic [31:0]            r_exit_code;
  logic [CNT_W-1:0]       r_cnt;
  logic [DW-1:0]          r_drain_cnt;

  assign w_run = (r_state == S_RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign print_ready_o[c] = r_up && w_run && !w_full[c];
    assign w_push[c]        = print_valid_i[c] && print_ready_o[c];
    assign w_pop[c]         = w_pop_any && (r_gnt == CHW'(c));
    assign w_elig[c]        = w_nl[c] || w_full[c] || ((r_state == S_DRAIN) && !w_empty[c]);
    tb_sim_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (w_flush),
      .push_i  (w_push[c]),
      .wdata_i (print_wdata_i[8*c +: 8]),
      .pop_i   (w_pop[c]),
      .head_o  (w_head[c]),
      .full_o  (w_full[c]),
      .empty_o (w_empty[c]),
      .nl_o    (w_nl[c])
    );
  end

  // Round-robin: the second pass (channels at/after the pointer) overrides the wrap-around pass.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = r_ptr;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_elig[i]) begin w_gnt_found = 1'b1; w_gnt_idx = CHW'(i); end
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_elig[i] && (CHW'(i) >= r_ptr)) begin w_gnt_found = 1'b1; w_gnt_idx = CHW'(i); end
  end

  assign w_head_sel  = w_head[r_gnt];
  assign w_empty_sel = w_empty[r_gnt];
  assign w_data_vld  = r_lock && !w_empty_sel && (r_state != S_DONE) && !w_tag_vld;
  assign w_pop_any   = w_data_vld && out_ready_i;
  assign w_unlock    = (w_pop_any && (w_head_sel == 8'h0A)) || (w_empty_sel && !w_tag_vld);
  assign out_valid_o = w_tag_vld || w_data_vld;
  assign out_ch_o    = r_gnt;
  assign out_char_o  = w_tag_vld ? w_tag_char : (w_data_vld ? w_head_sel : 8'h00);

`ifdef TB_SIM_CTRL_LINE_TAG_EN
  logic [1:0] r_tag;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         r_tag <= 2'd0;
    else if (w_flush)                  r_tag <= 2'd0;
    else if (!r_lock) begin
      if (w_gnt_found && r_state != S_DONE) r_tag <= 2'd2;
    end else if (w_tag_vld && out_ready_i) r_tag <= r_tag - 2'd1;
  end
  assign w_tag_vld  = r_lock && (r_tag != 2'd0) && (r_state != S_DONE);
  assign w_tag_char = (r_tag == 2'd2) ? (8'h30 + 8'(r_gnt)) : 8'h3A;
`else
  assign w_tag_vld  = 1'b0;
  assign w_tag_char = 8'h00;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock <= 1'b0; r_gnt <= '0; r_ptr <= '0;
    end else if (w_flush) begin
      r_lock <= 1'b0;
    end else if (r_lock) begin
      if (w_unlock) begin
        r_lock <= 1'b0;
        r_ptr  <= (r_gnt == LAST_CH) ? '0 : r_gnt + CHW'(1);
      end
    end else if (w_gnt_found && r_state != S_DONE) begin
      r_lock <= 1'b1;
      r_gnt  <= w_gnt_idx;
    end
  end

  assign w_to  = (max_cycles_i != '0) && (r_cnt >= max_cycles_i);
  assign w_evt = w_run && (tests_failed_i || exit_valid_i || tests_passed_i || w_to);

  always_comb begin
    w_evt_status = 3'd4;
    if (tests_failed_i)      w_evt_status = 3'd2;
    else if (exit_valid_i)   w_evt_status = 3'd3;
    else if (tests_passed_i) w_evt_status = 3'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_drain_to  = 1'b0;
    case (r_state)
      S_RUN:   if (w_evt) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if ((&w_empty) && !r_lock) w_state_nxt = S_DONE;
        else if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt = S_DONE;
          w_flush     = 1'b1;
          w_drain_to  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // The event cycle itself does not count, so a timeout reports exactly max_cycles_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_up <= 1'b0; r_status <= 3'd0; r_exit_code <= '0; r_cnt <= '0; r_drain_cnt <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_evt) begin
        r_status <= w_evt_status;
        if (w_evt_status == 3'd3) r_exit_code <= exit_value_i;
      end else if (w_drain_to) begin
        r_status <= 3'd5;
      end
      if (w_run && !w_evt && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DW'(1);
    end
  end

  assign done_o      = (r_state == S_DONE);
  assign status_o    = r_status;
  assign exit_code_o = r_exit_code;
  assign cycle_cnt_o = r_cnt;
endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Directed bench for tb_sim_ctrl (NUM_CH=2, FIFO_DEPTH=64): a cycle table plus multi-cycle stream sequences.
module tb_tb_sim_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  print_valid_i;
  logic [15:0] print_wdata_i;
  logic [1:0]  print_ready_o;
  logic        out_valid_o, out_ready_i;
  logic        out_ch_o;
  logic [7:0]  out_char_o;
  logic        tests_passed_i, tests_failed_i, exit_valid_i;
  logic [31:0] exit_value_i, max_cycles_i;
  logic        done_o;
  logic [2:0]  status_o;
  logic [31:0] exit_code_o, cycle_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] q[$];

  tb_sim_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .print_valid_i(print_valid_i), .print_wdata_i(print_wdata_i), .print_ready_o(print_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ch_o(out_ch_o), .out_char_o(out_char_o),
    .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i), .max_cycles_i(max_cycles_i),
    .done_o(done_o), .status_o(status_o), .exit_code_o(exit_code_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Every completed handshake, as {channel, char}.
  always @(posedge clk_i) if (!rst_i && out_valid_o && out_ready_i) q.push_back({out_ch_o, out_char_o});

  typedef struct {
    logic [1:0]  pv;
    logic [15:0] wd;
    logic        pass;
    logic        fail;
    logic [1:0]  e_prdy;
    logic        e_ov;
    logic        e_ch;
    logic [7:0]  e_char;
    logic        e_done;
    logic [2:0]  e_st;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic do_reset(input logic [31:0] maxc);
    rst_i = 1'b1; print_valid_i = '0; print_wdata_i = '0; out_ready_i = 1'b0;
    tests_passed_i = 0; tests_failed_i = 0; exit_valid_i = 0; exit_value_i = '0;
    max_cycles_i = maxc;
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset_outputs",
        {print_ready_o, out_valid_o, out_ch_o, out_char_o, done_o, status_o, exit_code_o, cycle_cnt_o}, 64'h0);
    rst_i = 1'b0;
    q.delete();
  endtask

  task automatic push(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
    print_valid_i = v; print_wdata_i = {c1, c0};
    step();
    print_valid_i = '0;
  endtask

  task automatic wait_beats(input string nm, input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin step(); k++; end
    chk(nm, 64'(q.size() >= n), 64'd1);
  endtask

  task automatic chk_stream(input string nm, input string s, input string chs);
    chk({nm, "_len"}, 64'(q.size()), 64'(s.len()));
    for (int i = 0; i < s.len() && i < q.size(); i++)
      chk(nm, 64'(q[i]), 64'({chs[i] == "1", s[i]}));
  endtask

  initial begin
    int k;
    logic [31:0] cnt_at;

    // Single line "hi\n" on ch0 with out_ready_i=1, then a pass event; cycle_cnt_o starts at 1 after the first edge.
    tbl[0]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd1};
    tbl[1]  = '{2'b01, 16'h0068, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd2};
    tbl[2]  = '{2'b01, 16'h0069, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd3};
    tbl[3]  = '{2'b01, 16'h000A, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd4};
    tbl[4]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 1, 0, 8'h68, 0, 3'd0, 32'd5};
    tbl[5]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 1, 0, 8'h69, 0, 3'd0, 32'd6};
    tbl[6]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 1, 0, 8'h0A, 0, 3'd0, 32'd7};
    tbl[7]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd8};
    tbl[8]  = '{2'b00, 16'h0000, 0, 0, 2'b11, 0, 0, 8'h00, 0, 3'd0, 32'd9};
    tbl[9]  = '{2'b00, 16'h0000, 1, 0, 2'b00, 0, 0, 8'h00, 0, 3'd1, 32'd9};
    tbl[10] = '{2'b00, 16'h0000, 0, 0, 2'b00, 0, 0, 8'h00, 1, 3'd1, 32'd9};
    tbl[11] = '{2'b00, 16'h0000, 0, 1, 2'b00, 0, 0, 8'h00, 1, 3'd1, 32'd9};

    do_reset(32'd0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      print_valid_i = tbl[i].pv; print_wdata_i = tbl[i].wd;
      tests_passed_i = tbl[i].pass; tests_failed_i = tbl[i].fail;
      step();
      chk($sformatf("table[%0d]", i),
          64'({print_ready_o, out_valid_o, out_ch_o, out_char_o, done_o, status_o, cycle_cnt_o}),
          64'({tbl[i].e_prdy, tbl[i].e_ov, tbl[i].e_ch, tbl[i].e_char, tbl[i].e_done, tbl[i].e_st, tbl[i].e_cnt}));
    end
    tests_passed_i = 0; tests_failed_i = 0;

    // Interleaved pushes on both channels: whole lines, ch0 first.
    do_reset(32'd0);
    step();
    out_ready_i = 1'b1;
    push(2'b11, "a", "X");
    push(2'b11, "b", "Y");
    push(2'b11, 8'h0A, 8'h0A);
    wait_beats("interleave_done", 6, 60);
    repeat (3) step();
    chk_stream("interleave", "ab\nXY\n", "000111");

    // Full FIFO with no newline is emitted as a partial line.
    do_reset(32'd0);
    step();
    for (int i = 0; i < 64; i++) push(2'b10, 8'h00, "z");
    chk("full_ready", 64'(print_ready_o), 64'(2'b01));
    step();
    chk("full_lock", 64'({out_valid_o, out_ch_o, out_char_o}), 64'({1'b1, 1'b1, 8'h7A}));
    out_ready_i = 1'b1;
    step();
    chk("full_ready_back", 64'(print_ready_o), 64'(2'b11));
    wait_beats("full_drain", 64, 200);
    repeat (3) step();
    chk("full_count", 64'(q.size()), 64'd64);
    k = 0;
    foreach (q[i]) if (q[i] !== {1'b1, 8'h7A}) k++;
    chk("full_all_z_ch1", 64'(k), 64'd0);
    chk("full_idle", 64'(out_valid_o), 64'd0);

    // Backpressure mid-line.
    do_reset(32'd0);
    step();
    out_ready_i = 1'b1;
    push(2'b01, "a", 8'h00); push(2'b01, "b", 8'h00); push(2'b01, "c", 8'h00);
    push(2'b01, "d", 8'h00); push(2'b01, 8'h0A, 8'h00);
    wait_beats("bp_first2", 2, 40);
    out_ready_i = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(out_valid_o && out_char_o == "c" && out_ch_o == 1'b0)) k++;
    end
    chk("bp_stable", 64'(k), 64'd0);
    chk("bp_no_extra", 64'(q.size()), 64'd2);
    out_ready_i = 1'b1;
    wait_beats("bp_rest", 5, 40);
    repeat (3) step();
    chk_stream("bp", "abcd\n", "00000");

    // Simultaneous pass and exit: exit wins; drain includes ch1's partial line.
    do_reset(32'd0);
    step();
    push(2'b11, "o", "p");
    push(2'b11, "k", "q");
    push(2'b01, 8'h0A, 8'h00);
    repeat (2) step();
    tests_passed_i = 1; exit_valid_i = 1; exit_value_i = 32'd5;
    step();
    tests_passed_i = 0; exit_valid_i = 0; exit_value_i = 32'd9;
    chk("sim_evt", 64'({status_o, exit_code_o, print_ready_o, done_o}), 64'({3'd3, 32'd5, 2'b00, 1'b0}));
    cnt_at = cycle_cnt_o;
    out_ready_i = 1'b1;
    k = 0;
    while (!done_o && k < 100) begin step(); k++; end
    chk("sim_done", 64'(done_o), 64'd1);
    chk_stream("sim_drain", "ok\npq", "00011");
    exit_valid_i = 1;
    step();
    exit_valid_i = 0;
    chk("sim_sticky", 64'({status_o, exit_code_o, cycle_cnt_o, done_o, out_valid_o}),
        64'({3'd3, 32'd5, cnt_at, 1'b1, 1'b0}));

    // Watchdog at 100 cycles.
    do_reset(32'd100);
    k = 0;
    while (status_o == 3'd0 && k < 200) begin step(); k++; end
    chk("wd_status", 64'({status_o, cycle_cnt_o}), 64'({3'd4, 32'd100}));
    chk("wd_when", 64'(k), 64'd101);
    tests_failed_i = 1;
    step();
    tests_failed_i = 0;
    chk("wd_done", 64'({done_o, status_o, cycle_cnt_o}), 64'({1'b1, 3'd4, 32'd100}));

    // Watchdog disabled.
    do_reset(32'd0);
    repeat (10000) step();
    chk("wd_off", 64'({done_o, status_o, cycle_cnt_o}), 64'({1'b0, 3'd0, 32'd10000}));

    // Drain timeout: output stalled, contents discarded after DRAIN_MAX cycles.
    do_reset(32'd0);
    step();
    push(2'b01, "x", 8'h00);
    push(2'b01, 8'h0A, 8'h00);
    tests_failed_i = 1;
    step();
    tests_failed_i = 0;
    chk("dt_evt", 64'(status_o), 64'd2);
    repeat (1023) step();
    chk("dt_before", 64'({done_o, status_o}), 64'({1'b0, 3'd2}));
    step();
    chk("dt_after", 64'({done_o, status_o}), 64'({1'b1, 3'd5}));
    out_ready_i = 1'b1;
    repeat (4) step();
    chk("dt_discard", 64'({q.size() != 0, out_valid_o, print_ready_o}), 64'd0);

    // Asynchronous reset mid-line.
    do_reset(32'd0);
    step();
    push(2'b01, "a", 8'h00); push(2'b01, "b", 8'h00); push(2'b01, 8'h0A, 8'h00);
    repeat (2) step();
    chk("mid_locked", 64'({out_valid_o, out_char_o}), 64'({1'b1, 8'h61}));
    #1 rst_i = 1'b1;
    #1;
    chk("mid_reset", 64'({print_ready_o, out_valid_o, out_ch_o, out_char_o, done_o, status_o, cycle_cnt_o}), 64'h0);
    step();
    rst_i = 1'b0;
    repeat (5) step();
    chk("mid_after", 64'({out_valid_o, print_ready_o, cycle_cnt_o}), 64'({1'b0, 2'b11, 32'd5}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
